and_bist: RTL and testbench
===========================

// Module: and_bist
// PURPOSE
//  Synthesizable exhaustive self-test engine for the REG_WIDTH-bit bitwise AND block.
//  Drives every {a,b} combination into a DUT instance, checks y against a&b, and
//  reports the pass/fail result and the error count. It is the checking end of the
//  same a/b/y interface. It gives on-chip and bench-free coverage of AND and its
//  pipelined variants.
// PARAMETERS
//  REG_WIDTH    3   operand width of DUT a/b/y; legal 1..8 (sweep counter is 2*REG_WIDTH bits)
//  DUT_LATENCY  0   clock cycles from a/b change to valid y (0 = combinational DUT)
// PORTS
//  clk           in   1              single clock, rising edge
//  rst_n         in   1              asynchronous, active-low reset
//  start         in   1              1-cycle pulse; begins a sweep when not busy
//  dut_a         out  REG_WIDTH      operand a to DUT (registered)
//  dut_b         out  REG_WIDTH      operand b to DUT (registered)
//  dut_y         in   REG_WIDTH      DUT result
//  busy          out  1              sweep in progress
//  done          out  1              sweep finished; held until next start or reset
//  pass          out  1              done && err_count==0
//  err_count     out  2*REG_WIDTH+1  number of mismatching vectors in the last sweep
//  first_fail_a  out  REG_WIDTH      a of the first mismatching vector (0 if none)
//  first_fail_b  out  REG_WIDTH      b of the first mismatching vector (0 if none)
// BEHAVIOUR
//  - Reset: asynchronous, to IDLE. All outputs are 0. Reset mid-sweep aborts at once with no partial result.
//  - FSM states:
//    - IDLE: start -> APPLY. Clears err_count, first_fail_*, done and the vector counter. Sets busy.
//    - APPLY: holds the vector for DUT_LATENCY+1 cycles. A wait counter counts 0..DUT_LATENCY.
//    - On the last APPLY cycle, dut_y is compared with dut_a&dut_b at the rising edge.
//      On mismatch, err_count increments. On the first mismatch, dut_a/dut_b are captured into first_fail_*.
//    - After the compare, if the counter is not all-ones: counter+1 and stay in APPLY.
//      Otherwise -> DONE with busy=0, done=1.
//    - DONE: outputs are held. start -> same as the IDLE start (restart, results cleared).
//  - Vector order: counter cnt[2W-1:0], a=cnt[2W-1:W], b=cnt[W-1:0]. b varies fastest:
//    (0,0),(0,1),...,(0,2^W-1),(1,0)...
//  - Timing: start is sampled at edge T0; vector 0 appears after T0.
//    Vector k is compared at edge T0+(k+1)*(DUT_LATENCY+1).
//    busy falls and done rises at the same edge as the final compare.
//  - Sweep length: 2^(2W)*(DUT_LATENCY+1) cycles. For W=3, L=0 that is 64.
//  - start while busy is ignored; the sweep is not restarted.
//  - err_count cannot overflow: its maximum is 2^(2W) and its width is 2W+1.
//  - pass is combinational from done and err_count. It is 0 whenever done=0.
//  - dut_y is treated as synchronous to clk. X/Z on dut_y counts as a mismatch in simulation.
// TESTING
//  - W=3, L=0, correct comb AND; pulse start -> busy for 64 cycles; done=1, pass=1, err_count=0.
//  - W=3, L=0, DUT with y[0] stuck-at-1 -> err_count=48, first_fail_a=0, first_fail_b=0, pass=0.
//  - W=3, L=2, AND registered twice -> pass=1 after 192 cycles.
//    Same DUT with L=0 -> pass=0, err_count>0.
//  - start pulsed again at cycle 20 of a sweep -> ignored; done still rises at cycle 64.
//    Results match the no-pulse run.
//  - rst_n low at cycle 30 of a sweep -> outputs 0 immediately, done never rises.
//    Then start -> full clean sweep, pass=1.
//  - After a failing sweep, swap in a good DUT and pulse start in DONE ->
//    err_count and first_fail_* clear; the final pass=1.

Source files
------------

// File: rtl/and_bist.sv
// Exhaustive self-test engine for a REG_WIDTH-bit bitwise AND: sweeps every {a,b}, checks y == a&b.
// Latency: each vector held DUT_LATENCY+1 cycles; full sweep is 2^(2*REG_WIDTH)*(DUT_LATENCY+1) cycles.
// Backpressure: none; start is ignored while busy, results held in DONE until the next start or reset.
module and_bist #(
    parameter int REG_WIDTH   = 3,
    parameter int DUT_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [REG_WIDTH-1:0]   dut_a,
    output logic [REG_WIDTH-1:0]   dut_b,
    input  logic [REG_WIDTH-1:0]   dut_y,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2*REG_WIDTH:0]   err_count,
    output logic [REG_WIDTH-1:0]   first_fail_a,
    output logic [REG_WIDTH-1:0]   first_fail_b
);

    localparam int CW = 2 * REG_WIDTH;
    localparam int WW = (DUT_LATENCY > 0) ? $clog2(DUT_LATENCY + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(DUT_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [WW-1:0]        wait_q;
    logic [CW:0]          err_q;
    logic [REG_WIDTH-1:0] ffa_q;
    logic [REG_WIDTH-1:0] ffb_q;
    logic                 busy_q;
    logic                 done_q;

    logic [REG_WIDTH-1:0] exp_y;
    logic                 y_ok;
    logic                 last_wait;
    logic                 cnt_full;

    // Operands come straight from the sweep counter, b in the low half so it varies fastest
    assign dut_a = cnt_q[CW-1:REG_WIDTH];
    assign dut_b = cnt_q[REG_WIDTH-1:0];

    // Compare terms for the current vector
    always_comb begin
        exp_y     = dut_a & dut_b;
        // An X/Z bit makes y_ok unknown, which lands in the mismatch branch below
        y_ok      = ((dut_y ^ exp_y) == '0);
        last_wait = (wait_q == WAIT_LAST);
        cnt_full  = &cnt_q;
    end

    // Sweep controller: IDLE/DONE wait for start, APPLY holds each vector then compares
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            ffa_q   <= '0;
            ffb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_APPLY;
                        cnt_q   <= '0;
                        wait_q  <= '0;
                        err_q   <= '0;
                        ffa_q   <= '0;
                        ffb_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (!last_wait) begin
                        wait_q <= wait_q + 1'b1;
                    end else begin
                        wait_q <= '0;
                        if (y_ok) begin
                            err_q <= err_q;
                        end else begin
                            err_q <= err_q + 1'b1;
                            // Capture only the first failing vector of the sweep
                            if (err_q == '0) begin
                                ffa_q <= dut_a;
                                ffb_q <= dut_b;
                            end
                        end
                        if (cnt_full) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_count    = err_q;
    assign first_fail_a = ffa_q;
    assign first_fail_b = ffb_q;
    assign pass         = done_q && (err_q == '0);

endmodule

// File: tb/tb_and_bist.sv
// Bench for and_bist: two engines (latency 0 and 2) each driving a behavioural AND device model.
// Device faults are chosen per sweep; expected results are computed by enumerating all vectors.
// Start/reset are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_and_bist;

    localparam int W  = 3;
    localparam int NV = 1 << (2 * W);

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start2;

    logic [W-1:0]   a0, b0, y0, fa0, fb0;
    logic           busy0, done0, pass0;
    logic [2*W:0]   err0;

    logic [W-1:0]   a2, b2, y2, fa2, fb2;
    logic           busy2, done2, pass2;
    logic [2*W:0]   err2;

    int checks = 0;
    int errors = 0;

    // Device model controls: 0 good, 1 y[0] stuck-at-1, 2 random bit flips, 3 AND registered twice
    int       mode;
    logic [W-1:0] flipmask [NV];
    logic [W-1:0] p1_0, p2_0, p1_2, p2_2;

    always #5 clk = ~clk;

    and_bist #(.REG_WIDTH(W), .DUT_LATENCY(0)) u_bist0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_a(fa0), .first_fail_b(fb0)
    );

    and_bist #(.REG_WIDTH(W), .DUT_LATENCY(2)) u_bist2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_a(fa2), .first_fail_b(fb2)
    );

    // Combinational faulty-AND behaviour for a single vector
    function automatic logic [W-1:0] dev_y(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] y;
        y = a & b;
        if (m == 1) y[0] = 1'b1;
        else if (m == 2) y = y ^ flipmask[{a, b}];
        return y;
    endfunction

    // Two-stage registered AND devices
    always @(posedge clk) begin
        p1_0 <= a0 & b0;
        p2_0 <= p1_0;
        p1_2 <= a2 & b2;
        p2_2 <= p1_2;
    end

    always_comb begin
        y0 = (mode == 3) ? p2_0 : dev_y(mode, a0, b0);
        y2 = p2_2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: enumerate every (a,b) in sweep order, count mismatches and the first failing pair
    task automatic ref_sweep(input int m, output int e, output int fa, output int fb);
        e = 0; fa = 0; fb = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                if (dev_y(m, W'(a), W'(b)) != W'(a & b)) begin
                    if (e == 0) begin fa = a; fb = b; end
                    e++;
                end
            end
        end
    endtask

    // Pulse start on engine 0 and run until done; optional extra start pulse mid-sweep
    task automatic sweep0(input int pulse_at, output int n, output int busy_bad,
                          output int e1, output int fa1, output int fb1, output int d1, output int p1);
        n = 0; busy_bad = 0; e1 = 0; fa1 = 0; fb1 = 0; d1 = 0; p1 = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        while (!done0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                e1 = int'(err0); fa1 = int'(fa0); fb1 = int'(fb0); d1 = int'(done0); p1 = int'(pass0);
            end
            if (!done0 && !busy0) busy_bad++;
            start0 = (n == pulse_at);
        end
        start0 = 1'b0;
    endtask

    initial begin
        int n, bb, e1, fa1, fb1, d1, p1, ee, efa, efb;
        rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; mode = 0;
        for (int i = 0; i < NV; i++) flipmask[i] = '0;

        // Reset state of both engines
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs0", {busy0, done0, pass0, err0, fa0, fb0, a0, b0}, 0);
        chk("rst_outs2", {busy2, done2, pass2, err2, fa2, fb2, a2, b2}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Good combinational AND
        mode = 0;
        sweep0(0, n, bb, e1, fa1, fb1, d1, p1);
        chk("good_len", n, NV);
        chk("good_busy", bb, 0);
        chk("good_res", {done0, busy0, pass0, err0}, {3'b101, 7'd0});

        // y[0] stuck-at-1
        mode = 1;
        ref_sweep(1, ee, efa, efb);
        sweep0(0, n, bb, e1, fa1, fb1, d1, p1);
        chk("sa1_ref_err", ee, 48);
        chk("sa1_err", err0, ee);
        chk("sa1_ff", {fa0, fb0}, {W'(efa), W'(efb)});
        chk("sa1_pass", pass0, 0);
        chk("sa1_pass_low_mid", p1, 0);

        // Random flip patterns on a random subset of vectors
        mode = 2;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NV; i++)
                flipmask[i] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(1, 7)) : '0;
            flipmask[$urandom_range(1, NV - 1)] = W'($urandom_range(1, 7));
            ref_sweep(2, ee, efa, efb);
            sweep0(0, n, bb, e1, fa1, fb1, d1, p1);
            chk("rnd_len", n, NV);
            chk("rnd_err", err0, ee);
            chk("rnd_ffa", fa0, efa);
            chk("rnd_ffb", fb0, efb);
            chk("rnd_pass", pass0, 0);
        end

        // Swap in a good device and restart from DONE: results clear, final pass
        mode = 0;
        sweep0(0, n, bb, e1, fa1, fb1, d1, p1);
        chk("restart_clr_err", e1, 0);
        chk("restart_clr_ff", {fa1[W-1:0], fb1[W-1:0]}, 0);
        chk("restart_clr_done", d1, 0);
        chk("restart_pass", {pass0, err0}, {1'b1, 7'd0});

        // Extra start pulse during the sweep is ignored
        mode = 1;
        sweep0(20, n, bb, e1, fa1, fb1, d1, p1);
        chk("ign_len", n, NV);
        chk("ign_err", err0, 48);
        chk("ign_ff", {fa0, fb0}, 0);

        // Registered-twice AND against a latency-0 engine must fail
        mode = 3;
        sweep0(0, n, bb, e1, fa1, fb1, d1, p1);
        chk("lat_mis_pass", pass0, 0);
        chk("lat_mis_errnz", (err0 != 0), 1);

        // Registered-twice AND against the latency-2 engine
        n = 0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        while (!done2 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk("l2_len", n, NV * 3);
        chk("l2_res", {pass2, err2}, {1'b1, 7'd0});

        // Reset in the middle of a sweep
        mode = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_busy_before", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {busy0, done0, pass0, err0, fa0, fb0, a0, b0}, 0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done0) n++;
        end
        chk("midrst_no_done", n, 0);

        // Clean sweep after the abort
        sweep0(0, n, bb, e1, fa1, fb1, d1, p1);
        chk("post_rst_len", n, NV);
        chk("post_rst_pass", {pass0, err0}, {1'b1, 7'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
